// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - parametrised LCD timing generator with run/stop control
module lcd_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 48,
    parameter int H_BP     = 40,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 13,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 29,
    parameter int CLK_DIV  = 2,
    parameter int SYNC_LOW = 1,
    parameter int XW       = 10,
    parameter int YW       = 10
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          run,
    input  logic          mode_de,
    output logic          pix_ce,
    output logic          DISP_CLK,
    output logic          DEN,
    output logic          HSYNC,
    output logic          VSYNC,
    output logic [XW-1:0] DrawX,
    output logic [YW-1:0] DrawY,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

    localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);

    // One extra bit so region bounds equal to 2**XW / 2**YW still compare correctly
    localparam logic [XW:0] H_ACT  = (XW+1)'(H_ACTIVE);
    localparam logic [XW:0] HS_BEG = (XW+1)'(H_ACTIVE + H_FP);
    localparam logic [XW:0] HS_END = (XW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW:0] V_ACT  = (YW+1)'(V_ACTIVE);
    localparam logic [YW:0] VS_BEG = (YW+1)'(V_ACTIVE + V_FP);
    localparam logic [YW:0] VS_END = (YW+1)'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_OFF = (SYNC_LOW != 0);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [DW-1:0]   div_cnt;
    logic [DW-1:0]   div_n;
    logic            tick;
    logic [XW-1:0]   hcnt;
    logic [XW-1:0]   hcnt_n;
    logic [YW-1:0]   vcnt;
    logic [YW-1:0]   vcnt_n;
    logic            last_px;
    logic            active_n;
    logic            ls_n;
    logic            fs_n;
    logic            mode_q;
    logic            mode_eff;
    logic            den_n;
    logic            hs_on;
    logic            vs_on;

    always_comb begin
        tick  = (div_cnt == DIV_LAST);
        div_n = tick ? '0 : div_cnt + 1'b1;
    end

    assign last_px = (hcnt == H_LAST) && (vcnt == V_LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // IDLE leaves only on a pixel strobe so the first RUN pixel is a full (0,0) period
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (run && tick) begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (!run) begin
                    state_n = (tick && last_px) ? S_IDLE : S_STOPPING;
                end
            end
            S_STOPPING: begin
                if (run) begin
                    state_n = S_RUN;
                end else if (tick && last_px) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        hcnt_n = hcnt;
        vcnt_n = vcnt;
        if (state_n == S_IDLE) begin
            hcnt_n = '0;
            vcnt_n = '0;
        end else if (tick && (state != S_IDLE)) begin
            if (hcnt == H_LAST) begin
                hcnt_n = '0;
                vcnt_n = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
            end else begin
                hcnt_n = hcnt + 1'b1;
            end
        end
    end

    // Everything below describes the position the counters are about to load
    always_comb begin
        active_n = tick && (state_n != S_IDLE);
        ls_n     = active_n && (hcnt_n == '0);
        fs_n     = ls_n && (vcnt_n == '0);
        mode_eff = fs_n ? mode_de : mode_q;
        den_n    = (state_n != S_IDLE) && ({1'b0, hcnt_n} < H_ACT) && ({1'b0, vcnt_n} < V_ACT);
        hs_on    = (state_n != S_IDLE) && !mode_eff
                   && ({1'b0, hcnt_n} >= HS_BEG) && ({1'b0, hcnt_n} < HS_END);
        vs_on    = (state_n != S_IDLE) && !mode_eff
                   && ({1'b0, vcnt_n} >= VS_BEG) && ({1'b0, vcnt_n} < VS_END);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_cnt     <= '0;
            hcnt        <= '0;
            vcnt        <= '0;
            mode_q      <= 1'b0;
            pix_ce      <= 1'b0;
            DISP_CLK    <= 1'b0;
            DEN         <= 1'b0;
            HSYNC       <= SYNC_OFF;
            VSYNC       <= SYNC_OFF;
            DrawX       <= '0;
            DrawY       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= div_n;
            hcnt        <= hcnt_n;
            vcnt        <= vcnt_n;
            pix_ce      <= (div_n == DIV_LAST);
            DISP_CLK    <= (div_n >= DIV_HALF);
            line_start  <= ls_n;
            frame_start <= fs_n;
            if (fs_n) begin
                mode_q <= mode_de;
            end
            if (tick) begin
                DEN   <= den_n;
                HSYNC <= hs_on ^ SYNC_OFF;
                VSYNC <= vs_on ^ SYNC_OFF;
                DrawX <= den_n ? hcnt_n : '0;
                DrawY <= den_n ? vcnt_n : '0;
            end
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb/tb_lcd_timing_gen.sv - directed bench for lcd_timing_gen at three geometries
module tb_lcd_timing_gen;

    logic Clk;
    logic Reset;
    logic run;
    logic mode_de;

    logic       d_pix_ce, d_DISP_CLK, d_DEN, d_HSYNC, d_VSYNC, d_line_start, d_frame_start;
    logic [9:0] d_DrawX, d_DrawY;
    logic       m_pix_ce, m_DISP_CLK, m_DEN, m_HSYNC, m_VSYNC, m_line_start, m_frame_start;
    logic [3:0] m_DrawX;
    logic [2:0] m_DrawY;
    logic       s_pix_ce, s_DISP_CLK, s_DEN, s_HSYNC, s_VSYNC, s_line_start, s_frame_start;
    logic [2:0] s_DrawX, s_DrawY;

    int checks = 0;
    int errors = 0;
    int m_fs_cnt = 0;

    lcd_timing_gen u_def (
        .Clk(Clk), .Reset(Reset), .run(run), .mode_de(mode_de),
        .pix_ce(d_pix_ce), .DISP_CLK(d_DISP_CLK), .DEN(d_DEN), .HSYNC(d_HSYNC), .VSYNC(d_VSYNC),
        .DrawX(d_DrawX), .DrawY(d_DrawY), .line_start(d_line_start), .frame_start(d_frame_start)
    );

    lcd_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(2), .SYNC_LOW(1), .XW(4), .YW(3)
    ) u_med (
        .Clk(Clk), .Reset(Reset), .run(run), .mode_de(mode_de),
        .pix_ce(m_pix_ce), .DISP_CLK(m_DISP_CLK), .DEN(m_DEN), .HSYNC(m_HSYNC), .VSYNC(m_VSYNC),
        .DrawX(m_DrawX), .DrawY(m_DrawY), .line_start(m_line_start), .frame_start(m_frame_start)
    );

    lcd_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(4), .SYNC_LOW(0), .XW(3), .YW(3)
    ) u_sml (
        .Clk(Clk), .Reset(Reset), .run(run), .mode_de(mode_de),
        .pix_ce(s_pix_ce), .DISP_CLK(s_DISP_CLK), .DEN(s_DEN), .HSYNC(s_HSYNC), .VSYNC(s_VSYNC),
        .DrawX(s_DrawX), .DrawY(s_DrawY), .line_start(s_line_start), .frame_start(s_frame_start)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Reset) m_fs_cnt = 0;
        else if (m_frame_start) m_fs_cnt = m_fs_cnt + 1;
    end

    typedef struct {
        int pix;
        bit den, hs, vs, ls, fs;
        int x, y;
        bit mode, run;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int pix, input bit den, input bit hs, input bit vs,
                                input bit ls, input bit fs, input int x, input int y,
                                input bit mode, input bit rn);
        vec_t v;
        v.pix = pix; v.den = den; v.hs = hs; v.vs = vs; v.ls = ls; v.fs = fs;
        v.x = x; v.y = y; v.mode = mode; v.run = rn;
        return v;
    endfunction

    function automatic logic [15:0] pack(input bit den, input bit hs, input bit vs, input bit ls,
                                         input bit fs, input int x, input int y);
        logic [3:0] xx;
        logic [2:0] yy;
        xx = 4'(x);
        yy = 3'(y);
        return {4'b0, den, hs, vs, ls, fs, xx, yy};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_fs(input int which, input int budget, output bit got);
        got = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge Clk);
            if ((which == 0 && d_frame_start) || (which == 1 && m_frame_start) ||
                (which == 2 && s_frame_start)) begin
                got = 1'b1;
                break;
            end
        end
        chk($sformatf("frame_start_timeout_%0d", which), int'(got), 1);
    endtask

    task automatic cmp_small(input int p);
        int h, v;
        bit den;
        h   = p % 7;
        v   = (p / 7) % 5;
        den = (h < 4) && (v < 2);
        chk($sformatf("small_pix_%0d", p),
            int'(pack(s_DEN, s_HSYNC, s_VSYNC, s_line_start, s_frame_start, int'(s_DrawX), int'(s_DrawY))),
            int'(pack(den, h == 5, v == 3, h == 0, (h == 0) && (v == 0), den ? h : 0, den ? v : 0)));
    endtask

    initial begin
        bit got;
        int cur;
        int den_cnt, hs_first, hs_len, x_err, y_err, vs_err, ls_mid, cnt_a, cnt_b;
        bit [3:0] dpat, ppat;

        // medium geometry: H 8/2/3/2 (15), V 4/1/2/1 (8); pixel = v*15 + h
        tbl.push_back(mk(  0, 1, 1, 1, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(  7, 1, 1, 1, 0, 0, 7, 0, 0, 1));
        tbl.push_back(mk(  8, 0, 1, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk( 10, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk( 12, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk( 13, 0, 1, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk( 14, 0, 1, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk( 15, 1, 1, 1, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk( 50, 1, 1, 1, 0, 0, 5, 3, 0, 1));
        tbl.push_back(mk( 60, 0, 1, 1, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk( 75, 0, 1, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk( 85, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(105, 0, 1, 1, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(119, 0, 1, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(120, 1, 1, 1, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(125, 1, 1, 1, 0, 0, 5, 0, 1, 1));
        tbl.push_back(mk(205, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(240, 1, 1, 1, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(325, 0, 1, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(360, 1, 1, 1, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(400, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(410, 1, 1, 1, 0, 0, 5, 3, 0, 1));
        tbl.push_back(mk(445, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(480, 1, 1, 1, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(510, 1, 1, 1, 1, 0, 0, 2, 0, 0));
        tbl.push_back(mk(599, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(600, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(630, 0, 1, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(631, 1, 1, 1, 1, 1, 0, 0, 0, 1));

        Reset = 1'b1;
        run = 1'b0;
        mode_de = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_m_den", int'(m_DEN), 0);
        chk("rst_m_hsync", int'(m_HSYNC), 1);
        chk("rst_m_vsync", int'(m_VSYNC), 1);
        chk("rst_d_hsync", int'(d_HSYNC), 1);
        chk("rst_s_hsync", int'(s_HSYNC), 0);
        chk("rst_s_vsync", int'(s_VSYNC), 0);
        chk("rst_m_dispclk", int'(m_DISP_CLK), 0);
        chk("rst_m_pixce", int'(m_pix_ce), 0);
        chk("rst_m_drawxy", int'({m_DrawX, m_DrawY}), 0);
        chk("rst_m_strobes", int'({m_line_start, m_frame_start}), 0);

        Reset = 1'b0;
        cnt_a = 0; cnt_b = 0; den_cnt = 0; ls_mid = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            cnt_a += int'(m_pix_ce);
            cnt_b += int'(m_DISP_CLK);
            den_cnt += int'(m_DEN);
            ls_mid += int'(m_frame_start) + int'(m_line_start);
        end
        chk("idle_pixce_count", cnt_a, 4);
        chk("idle_dispclk_count", cnt_b, 4);
        chk("idle_den_count", den_cnt, 0);
        chk("idle_strobe_count", ls_mid, 0);

        run = 1'b1;
        wait_fs(1, 10, got);
        if (got) begin
            cur = 0;
            foreach (tbl[i]) begin
                repeat (2 * (tbl[i].pix - cur)) @(negedge Clk);
                cur = tbl[i].pix;
                chk($sformatf("med_pix_%0d", tbl[i].pix),
                    int'(pack(m_DEN, m_HSYNC, m_VSYNC, m_line_start, m_frame_start, int'(m_DrawX), int'(m_DrawY))),
                    int'(pack(tbl[i].den, tbl[i].hs, tbl[i].vs, tbl[i].ls, tbl[i].fs, tbl[i].x, tbl[i].y)));
                mode_de = tbl[i].mode;
                run = tbl[i].run;
            end
            repeat (2) @(negedge Clk);
            #1;
            chk("med_frame_start_total", m_fs_cnt, 6);
        end

        // default geometry: reset held with run=1 must keep everything quiet
        Reset = 1'b1;
        run = 1'b1;
        mode_de = 1'b0;
        cnt_a = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            cnt_a += int'(d_DEN) + int'(d_frame_start) + int'(d_pix_ce);
        end
        chk("reset_wins", cnt_a, 0);
        Reset = 1'b0;
        wait_fs(0, 10, got);
        if (got) begin
            den_cnt = 0; hs_first = -1; hs_len = 0; x_err = 0; y_err = 0; vs_err = 0; ls_mid = 0;
            for (int i = 0; i <= 928 + 845; i++) begin
                if (i < 928) begin
                    den_cnt += int'(d_DEN);
                    if (!d_HSYNC) begin
                        if (hs_first < 0) hs_first = i;
                        hs_len++;
                    end
                    if (int'(d_DrawX) != ((i < 800) ? i : 0)) x_err++;
                    if (d_DrawY != 10'd0) y_err++;
                    if (!d_VSYNC) vs_err++;
                    if (i > 0 && d_line_start) ls_mid++;
                end
                if (i == 928) begin
                    chk("def_line_period", int'(d_line_start), 1);
                    chk("def_line1_xy", int'({d_DEN, d_DrawX, d_DrawY}), int'({1'b1, 10'd0, 10'd1}));
                end
                if (i < 928 + 845) repeat (2) @(negedge Clk);
            end
            chk("def_den_count", den_cnt, 800);
            chk("def_hsync_first", hs_first, 840);
            chk("def_hsync_len", hs_len, 48);
            chk("def_drawx_errors", x_err, 0);
            chk("def_drawy_errors", y_err, 0);
            chk("def_vsync_errors", vs_err, 0);
            chk("def_line_start_mid", ls_mid, 0);
            chk("def_hsync_at_845", int'(d_HSYNC), 0);
        end
        Reset = 1'b1;
        @(negedge Clk);
        chk("def_rst_mid_sync",
            int'({d_HSYNC, d_DEN, d_DrawX, d_DISP_CLK, d_pix_ce}), int'({1'b1, 1'b0, 10'd0, 1'b0, 1'b0}));
        run = 1'b0;
        Reset = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            cnt_a += int'(d_frame_start) + int'(d_line_start) + int'(d_DEN) + int'(!d_HSYNC);
            cnt_b += int'(d_DISP_CLK);
        end
        chk("def_idle_after_reset", cnt_a, 0);
        chk("def_idle_dispclk", cnt_b, 5);

        // small geometry, CLK_DIV=4, active-high syncs
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        run = 1'b1;
        wait_fs(2, 20, got);
        if (got) begin
            cmp_small(0);
            dpat[3] = s_DISP_CLK;
            ppat[3] = s_pix_ce;
            for (int k = 1; k < 4; k++) begin
                @(negedge Clk);
                dpat[3-k] = s_DISP_CLK;
                ppat[3-k] = s_pix_ce;
            end
            chk("small_dispclk_duty", int'(dpat), int'(4'b0011));
            chk("small_pixce_phase", int'(ppat), int'(4'b0001));
            for (int p = 1; p <= 35; p++) begin
                repeat ((p == 1) ? 1 : 4) @(negedge Clk);
                cmp_small(p);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
